// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, frame width, baud divisor helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    PARITY    = ST_PARITY,
    STOP      = ST_STOP,
    WAIT_HIGH = ST_WAIT_HIGH
  } rx_state_e;

  // Nearest-integer bit period in clock cycles (12 MHz / 115200 -> 104).
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bus: data with one-cycle ready / err strobes.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      ready;
  logic                      err;

  modport master (output data, ready, err);
  modport slave  (input  data, ready, err);
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer with configurable reset value; shared with button inputs.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
// Samples each bit at its centre using a per-bit cycle counter and presents
// each good byte on bus.data with a one-cycle bus.ready; framing (and parity)
// faults give a one-cycle bus.err and leave bus.data untouched.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int DW    = UART_DATA_BITS;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);

  rx_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [BIT_W-1:0] bit_idx, bit_idx_nx;
  logic [DW-1:0]    shreg, shreg_nx;
  logic [DW-1:0]    data_q, data_nx;
  logic             ready_q, ready_nx;
  logic             err_q, err_nx;
  logic             rx_s;      // synchronized line
  logic             rx_d;      // previous synchronized sample (edge register)
  logic             stop_ok;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Edge register resets low so a start bit needs the line seen high first.
  always_ff @(posedge clk) begin
    if (reset) rx_d <= 1'b0;
    else       rx_d <= rx_s;
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_nx;

  // Parity verdict captured in PARITY, consumed in STOP.
  always_ff @(posedge clk) begin
    if (reset) par_bad <= 1'b0;
    else       par_bad <= par_bad_nx;
  end

  assign stop_ok = rx_s && !par_bad;
`else
  assign stop_ok = rx_s;
`endif

  // Next-state, counter, shift register and strobe decode.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    data_nx    = data_q;
    ready_nx   = 1'b0;
    err_nx     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nx = par_bad;
`endif
    case (state)
      IDLE: begin
        if (rx_d && !rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        // Half-bit re-check rejects short glitches.
        if (cnt == CNT_HALF) begin
          cnt_nx     = '0;
          bit_idx_nx = '0;
          state_nx   = rx_s ? IDLE : DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nx     = '0;
          shreg_nx   = {rx_s, shreg[DW-1:1]};
          bit_idx_nx = bit_idx + 1'b1;
          if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_FULL) begin
          cnt_nx     = '0;
          par_bad_nx = ^{shreg, rx_s};
          state_nx   = STOP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nx = '0;
          if (stop_ok) begin
            data_nx  = shreg;
            ready_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            err_nx   = 1'b1;
            state_nx = WAIT_HIGH;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A held-low break must not turn into a stream of frames.
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      data_q  <= data_nx;
      ready_q <= ready_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.data  = data_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=16: stimulus pushes expected
// strobes, a negedge monitor pops and compares every ready/err it sees.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         vec = 0;
  int         miss = 0;
  int         first_ready_cyc = -1;
  int         start_cyc = 0;
  logic [7:0] last_good = 8'h00;

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (bus.ready || bus.err)) begin
      exp_t e;
      vec++;
      if (bus.ready && bus.err) begin
        miss++;
        $display("FAIL strobe_overlap: ready=1 err=1 together, required at most one");
      end else if (sb.size() == 0) begin
        miss++;
        $display("FAIL unexpected_strobe: ready=%0b err=%0b data=%02h, required no strobe",
                 bus.ready, bus.err, bus.data);
      end else begin
        e = sb.pop_front();
        if (bus.err !== e.is_err || bus.data !== e.data) begin
          miss++;
          $display("FAIL strobe: got err=%0b data=%02h, required err=%0b data=%02h",
                   bus.err, bus.data, e.is_err, e.data);
        end
      end
      if (bus.ready && first_ready_cyc < 0) first_ready_cyc = cyc;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit === 1'bx) rx = 1'b1;
`endif
    send_bit(stop_bit);
  endtask

  task automatic expect_ready(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    sb.push_back(e);
    last_good = b;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",  int'(bus.data),  0);
    check("reset_ready", int'(bus.ready), 0);
    check("reset_err",   int'(bus.err),   0);
    reset = 1'b0;
    idle(100);

    // Single frame and start-edge-to-ready latency.
    expect_ready(8'h31);
    start_cyc = cyc;
    send_frame(8'h31, 1'b1, ^8'h31);
    idle(20);
    check("latency", first_ready_cyc - start_cyc, LAT);
    check("data_31", int'(bus.data), 8'h31);

    // Back-to-back frames with exact-length stop bits.
    expect_ready(8'h31);
    expect_ready(8'h32);
    expect_ready(8'h32);
    send_frame(8'h31, 1'b1, ^8'h31);
    send_frame(8'h32, 1'b1, ^8'h32);
    send_frame(8'h32, 1'b1, ^8'h32);
    idle(20);
    check("data_b2b", int'(bus.data), 8'h32);

    // Short low glitch is a false start, then a clean frame.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    expect_ready(8'h41);
    send_frame(8'h41, 1'b1, ^8'h41);
    idle(20);
    check("data_41", int'(bus.data), 8'h41);

    // Stop bit low followed by a break: one err, data held.
    expect_err();
    send_frame(8'h55, 1'b0, ^8'h55);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    check("data_held", int'(bus.data), 8'h41);
    idle(20);
    expect_ready(8'h33);
    send_frame(8'h33, 1'b1, ^8'h33);
    idle(20);
    check("data_33", int'(bus.data), 8'h33);

    // Reset in the 4th data bit of 8'hF8; its tail is all ones, so no
    // falling edge follows the reset until the next real start bit.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_good = 8'h00;
    check("data_after_reset", int'(bus.data), 0);
    repeat (CPB / 2) @(negedge clk);
    for (int i = 4; i < 8; i++) send_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b1);
`endif
    send_bit(1'b1);
    idle(30);
    check("data_after_abort", int'(bus.data), 0);
    expect_ready(8'h31);
    send_frame(8'h31, 1'b1, ^8'h31);
    idle(20);
    check("data_after_reset_frame", int'(bus.data), 8'h31);

`ifdef UART_RX_PARITY_EN
    // Good and bad parity on 8'h31 (three ones -> even parity bit 1).
    expect_ready(8'h31);
    send_frame(8'h31, 1'b1, 1'b1);
    idle(20);
    expect_err();
    send_frame(8'h31, 1'b1, 1'b0);
    idle(20);
    check("data_parity", int'(bus.data), 8'h31);
`endif

    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that turns an asynchronous 8N1 UART line into parallel bytes with a one-cycle `ready` strobe. It sits directly upstream of `indicator` and drives its `data`/`ready` inputs: each received byte is presented on `data` with a single-cycle `ready` pulse. It runs in the single board clock domain and oversamples `rx` with a per-bit cycle counter.

## Interface
- `CLKS_PER_BIT`, 104, clock cycles per bit period (12 MHz / 115200); must be ≥ 4.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial line; idle high.
- `data`  output  8  last good byte; LSB is the first received bit.
- `ready`  output  1  one-cycle strobe; `data` is valid in that cycle.
- `err`  output  1  one-cycle strobe on a framing error, or on a parity error when parity is enabled.

## Operation
- `rx` passes through a 2-flop synchronizer, then an edge register. Synchronizer flops reset to 1; the edge register resets to 0, so the line must be seen high once after reset before a start bit is accepted.
- FSM states: IDLE, START, DATA, PARITY (only with `UART_RX_PARITY_EN`), STOP, WAIT_HIGH.
- IDLE
  - A falling edge on the synced `rx` (previous 1, current 0) moves to START and clears the counter.
- START
  - Waits `CLKS_PER_BIT/2` cycles (integer divide), then samples.
  - Sample 0: go to DATA with the counter cleared.
  - Sample 1: false start; return to IDLE with no strobe.
- DATA
  - Samples every `CLKS_PER_BIT` cycles, which places each sample at bit centre.
  - Shifts the sample into the MSB of an 8-bit shift register (right shift), so the first bit ends up at the LSB.
  - After 8 samples, go to PARITY if enabled, else STOP.
- STOP
  - Samples after `CLKS_PER_BIT` cycles.
  - Sample 1 with no parity fault: load `data` from the shift register, pulse `ready`, go to IDLE.
  - Otherwise: pulse `err`, leave `data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH
  - Stays until synced `rx` is 1, then goes to IDLE. This prevents a break (held-low line) from producing repeated frames.
- `ready` and `err` are never asserted in the same cycle and never for more than one cycle.
- `data` holds its value between frames and is not cleared by errors.
- Counter width: `$clog2(CLKS_PER_BIT)` bits. It counts up and is compared against `CLKS_PER_BIT-1`; no wrap beyond that terminal value.

## Timing
- Reset values: `data`=8'h00, `ready`=0, `err`=0, state IDLE, counter 0, shift register 0.
- Reset asserted mid-frame: the frame is aborted on the next edge and no strobe is issued. A partial frame still arriving after reset release is ignored until the line has been seen high and a new falling edge occurs.
- Latency, counted from the first `clk` edge that samples `rx` low at the pin, to `ready` high:
  - Base: 2 + 1 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles.
  - With parity: add `CLKS_PER_BIT`.
  - With `CLKS_PER_BIT`=16, the base figure is 155 cycles.
- `ready` rises in the cycle after the stop sample, i.e. mid-stop-bit. The FSM is already in IDLE, so a back-to-back start bit at the nominal stop-bit end is caught.
- `rx` glitches shorter than half a bit during IDLE are rejected by the START re-check.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is 8E1.
  - After the 8 data bits, a parity bit is sampled at bit centre.
  - Even parity over data plus parity bit must be 0. On mismatch, STOP still samples, but the frame ends with `err` and no `ready`.
- Not defined:
  - The frame is 8N1 and the PARITY state is absent.
  - `err` reports framing errors only.
- The port list is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants (localparam codes for IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Frame constant `UART_DATA_BITS`=8.
  - A helper function computing `CLKS_PER_BIT` from clock and baud rates, reused by a future `uart_tx`.
- One sub-module: `sync2`, a 2-flop synchronizer with a reset value parameter; it is also reused for button inputs.
- The FSM, counter, shift register and outputs live in `uart_rx` itself.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Send 8'h31 ("1") as 8N1 after 100 idle cycles -> exactly one `ready` pulse, `data`=8'h31, 155 cycles after the start edge; `err` stays 0.
- Send "1", "2", "2" back-to-back, with each stop bit exactly 16 cycles -> three `ready` pulses with `data` 8'h31, 8'h32, 8'h32; no `err`.
- Pulse `rx` low for 5 cycles, then high -> no `ready`, no `err`, FSM back in IDLE; a following 8'h41 frame is received correctly.
- Send 8'h55 with the stop bit forced low, then hold `rx` low for 64 cycles -> one `err` pulse only; `data` keeps its previous value; a following 8'h33 frame after the line returns high is received.
- Assert `reset` for 1 cycle at the 4th data bit of a frame -> no strobe, `data`=8'h00; a new 8'h31 frame yields `ready` with `data`=8'h31.
- With `UART_RX_PARITY_EN`:
  - 8'h31 sent with parity bit 1 -> `ready` with `data`=8'h31.
  - 8'h31 sent with parity bit 0 -> `err` pulse, no `ready`.
